// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer request bundle and registered CDB broadcast.
// master = producers/consumers side, slave = the arbiter.
`ifndef ROB_BIT
`define ROB_BIT 6
`endif

interface cdb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ROB_BIT = `ROB_BIT
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ROB_BIT-1:0] req_rob_id;
    logic [NUM_REQ*32-1:0]      req_value;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       cdb_valid;
    logic [ROB_BIT-1:0]         cdb_rob_id;
    logic [31:0]                cdb_value;
    logic [1:0]                 cdb_src;
    logic [15:0]                conflict_count;

    modport master (
        output req_valid, req_rob_id, req_value,
        input  req_ready, cdb_valid, cdb_rob_id,
        input  cdb_value, cdb_src, conflict_count
    );

    modport slave (
        input  req_valid, req_rob_id, req_value,
        output req_ready, cdb_valid, cdb_rob_id,
        output cdb_value, cdb_src, conflict_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer FIFOs drained round-robin onto one
// registered common data bus; clear flushes, rdy_in low stalls all.
`ifndef ROB_BIT
`define ROB_BIT 6
`endif

module cdb_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ROB_BIT   = `ROB_BIT,
    parameter int DEPTH_BIT = 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear,
    cdb_arbiter_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0] FULL = (DEPTH_BIT+1)'(DEPTH);
    localparam logic [DEPTH_BIT-1:0] P_ONE = DEPTH_BIT'(1);
    localparam logic [DEPTH_BIT:0] C_ONE = (DEPTH_BIT+1)'(1);

    logic [ROB_BIT-1:0]   r_rob  [NUM_REQ][DEPTH];
    logic [31:0]          r_val  [NUM_REQ][DEPTH];
    logic [DEPTH_BIT-1:0] r_head [NUM_REQ];
    logic [DEPTH_BIT-1:0] r_tail [NUM_REQ];
    logic [DEPTH_BIT:0]   r_cnt  [NUM_REQ];
    logic [1:0]           r_rr;
    logic                 r_cdb_valid;
    logic [ROB_BIT-1:0]   r_cdb_rob;
    logic [31:0]          r_cdb_val;
    logic [1:0]           r_cdb_src;
    logic [15:0]          r_conf;

    logic                 w_run;
    logic [NUM_REQ-1:0]   w_ne;
    logic [NUM_REQ-1:0]   w_ready;
    logic [NUM_REQ-1:0]   w_enq;
    logic [NUM_REQ-1:0]   w_sel;
    logic [NUM_REQ-1:0]   w_deq;
    logic                 w_found;
    logic                 w_gnt;
    logic [1:0]           w_gnt_src;
    logic [1:0]           w_rr_nxt;
    logic [ROB_BIT-1:0]   w_gnt_rob;
    logic [31:0]          w_gnt_val;
    logic [2:0]           w_ne_cnt;
    logic                 w_conflict;

    assign w_run = rdy_in && !clear;

    // FIFO status; ready looks only at the registered count
    always_comb begin
        w_ne     = '0;
        w_ready  = '0;
        w_enq    = '0;
        w_ne_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ne[i]    = r_cnt[i] != '0;
            w_ready[i] = r_cnt[i] < FULL;
            w_enq[i]   = w_run && bus.req_valid[i] && w_ready[i];
            w_ne_cnt   = w_ne_cnt + {2'b00, w_ne[i]};
        end
    end

    assign w_conflict = w_ne_cnt >= 3'd2;

    // Round-robin search starting at r_rr over entries present now
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && w_ne[i] &&
                    ((int'(r_rr) + k) % NUM_REQ) == i) begin
                    w_sel[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

    assign w_gnt = w_run && w_found;
    assign w_deq = w_run ? w_sel : '0;

    // Head-entry mux and next priority pointer for the winner
    always_comb begin
        w_gnt_src = '0;
        w_rr_nxt  = r_rr;
        w_gnt_rob = '0;
        w_gnt_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel[i]) begin
                w_gnt_src = 2'(i);
                w_rr_nxt  = (i == NUM_REQ-1) ? 2'd0 : 2'(i+1);
                w_gnt_rob = r_rob[i][r_head[i]];
                w_gnt_val = r_val[i][r_head[i]];
            end
        end
    end

    // FIFO payload storage; contents are don't-care while count is 0
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_enq[i]) begin
                r_rob[i][r_tail[i]] <= bus.req_rob_id[i*ROB_BIT +: ROB_BIT];
                r_val[i][r_tail[i]] <= bus.req_value[i*32 +: 32];
            end
        end
    end

    // Pointers, counts, arbitration state, CDB register, conflict count
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_head[i] <= '0;
                r_tail[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_rr        <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_rob   <= '0;
            r_cdb_val   <= '0;
            r_cdb_src   <= '0;
            r_conf      <= '0;
        end else if (rdy_in) begin
            if (w_conflict && r_conf != 16'hFFFF) begin
                r_conf <= r_conf + 16'd1;
            end
            if (clear) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    r_head[i] <= '0;
                    r_tail[i] <= '0;
                    r_cnt[i]  <= '0;
                end
                r_rr        <= '0;
                r_cdb_valid <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (w_enq[i]) begin
                        r_tail[i] <= r_tail[i] + P_ONE;
                    end
                    if (w_deq[i]) begin
                        r_head[i] <= r_head[i] + P_ONE;
                    end
                    if (w_enq[i] && !w_deq[i]) begin
                        r_cnt[i] <= r_cnt[i] + C_ONE;
                    end else if (!w_enq[i] && w_deq[i]) begin
                        r_cnt[i] <= r_cnt[i] - C_ONE;
                    end
                end
                r_cdb_valid <= w_gnt;
                if (w_gnt) begin
                    r_cdb_rob <= w_gnt_rob;
                    r_cdb_val <= w_gnt_val;
                    r_cdb_src <= w_gnt_src;
                    r_rr      <= w_rr_nxt;
                end
            end
        end
    end

    assign bus.req_ready      = w_ready;
    assign bus.cdb_valid      = r_cdb_valid;
    assign bus.cdb_rob_id     = r_cdb_rob;
    assign bus.cdb_value      = r_cdb_val;
    assign bus.cdb_src        = r_cdb_src;
    assign bus.conflict_count = r_conf;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a scoreboard queue of
// hand-ordered CDB results, checked by an independent monitor.
module tb_cdb_arbiter;
    localparam int NR = 3;
    localparam int RB = 6;

    typedef struct packed {
        logic [1:0]    src;
        logic [RB-1:0] rob;
        logic [31:0]   val;
    } sb_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear;

    cdb_arbiter_if #(.NUM_REQ(NR), .ROB_BIT(RB)) bus ();

    cdb_arbiter #(.NUM_REQ(NR), .ROB_BIT(RB), .DEPTH_BIT(1)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int  n_chk  = 0;
    int  n_fail = 0;
    sb_t sb_q[$];

    int       pph;
    int       pidx [NR];
    int       pcnt [NR];
    logic [NR-1:0] mask;

    function automatic sb_t mk(input int ph, input int i, input int k);
        sb_t t;
        t.src = 2'(i);
        t.rob = RB'(ph*12 + 4*i + k);
        t.val = {8'(ph+1), 8'(i), 8'(k), 8'h5A};
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int ph, input int i, input int k);
        sb_q.push_back(mk(ph, i, k));
    endtask

    task automatic load(input int ph, input int n0, input int n1,
                        input int n2);
        pph = ph;
        pcnt[0] = n0;
        pcnt[1] = n1;
        pcnt[2] = n2;
        for (int i = 0; i < NR; i++) pidx[i] = 0;
    endtask

    task automatic cycle(input logic rdy, input logic clr);
        logic [NR-1:0] acc;
        logic v;
        sb_t t;
        acc = '0;
        for (int i = 0; i < NR; i++) begin
            v = mask[i] && (pidx[i] < pcnt[i]);
            bus.req_valid[i] = v;
            if (v) begin
                t = mk(pph, i, pidx[i]);
                bus.req_rob_id[i*RB +: RB] = t.rob;
                bus.req_value[i*32 +: 32]  = t.val;
            end
        end
        rdy_in = rdy;
        clear  = clr;
        for (int i = 0; i < NR; i++)
            acc[i] = bus.req_valid[i] && bus.req_ready[i] && rdy && !clr;
        @(posedge clk_in);
        #1;
        for (int i = 0; i < NR; i++)
            if (acc[i]) pidx[i]++;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        chk(nm, 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: pop and compare on every enabled edge with a CDB broadcast
    initial begin
        sb_t e;
        logic en;
        forever begin
            @(posedge clk_in);
            en = rdy_in && !rst_in;
            #1;
            if (en && bus.cdb_valid) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_cdb: got rob %0h src %0d expected none",
                             bus.cdb_rob_id, bus.cdb_src);
                end else begin
                    e = sb_q.pop_front();
                    chk("mon_src", 32'(bus.cdb_src), 32'(e.src));
                    chk("mon_rob", 32'(bus.cdb_rob_id), 32'(e.rob));
                    chk("mon_val", bus.cdb_value, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mask   = '0;
        load(0, 0, 0, 0);
        bus.req_valid  = '0;
        bus.req_rob_id = '0;
        bus.req_value  = '0;
        rdy_in = 1'b1;
        clear  = 1'b0;
        rst_in = 1'b1;
        #12;
        chk("rst_ready", 32'(bus.req_ready), 32'h7);
        chk("rst_valid", 32'(bus.cdb_valid), 32'd0);
        chk("rst_rob", 32'(bus.cdb_rob_id), 32'd0);
        chk("rst_val", bus.cdb_value, 32'd0);
        chk("rst_src", 32'(bus.cdb_src), 32'd0);
        chk("rst_conf", 32'(bus.conflict_count), 32'd0);
        rst_in = 1'b0;

        // Single producer: 2-edge latency, then idle
        sb_q.push_back('{src: 2'd1, rob: RB'(5), val: 32'h1234});
        bus.req_valid = 3'b010;
        bus.req_rob_id[RB +: RB] = RB'(5);
        bus.req_value[32 +: 32]  = 32'h1234;
        @(posedge clk_in);
        #1;
        bus.req_valid = '0;
        chk("single_e0_valid", 32'(bus.cdb_valid), 32'd0);
        cycle(1'b1, 1'b0);
        chk("single_e1_valid", 32'(bus.cdb_valid), 32'd1);
        chk("single_e1_src", 32'(bus.cdb_src), 32'd1);
        chk("single_e1_rob", 32'(bus.cdb_rob_id), 32'd5);
        chk("single_e1_val", bus.cdb_value, 32'h1234);
        cycle(1'b1, 1'b0);
        chk("single_e2_valid", 32'(bus.cdb_valid), 32'd0);
        cycle(1'b1, 1'b1);

        // Full contention with producer 0 back-pressured after 3 pushes
        load(0, 4, 3, 3);
        mask = 3'b111;
        push(0, 0, 0); push(0, 1, 0); push(0, 2, 0);
        push(0, 0, 1); push(0, 1, 1); push(0, 2, 1);
        push(0, 0, 2); push(0, 1, 2); push(0, 2, 2);
        push(0, 0, 3);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk("bp_ready", 32'(bus.req_ready), 32'h2);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        drain("cont_drain");
        chk("cont_conf", 32'(bus.conflict_count), 32'd9);

        // Flush with entries pending and requests in the clear cycle
        load(1, 3, 3, 3);
        push(1, 1, 0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        mask = '0;
        chk("flush_ready", 32'(bus.req_ready), 32'h7);
        chk("flush_valid", 32'(bus.cdb_valid), 32'd0);
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 1'b0);
            chk("flush_idle_valid", 32'(bus.cdb_valid), 32'd0);
        end
        chk("flush_conf", 32'(bus.conflict_count), 32'd11);
        chk("flush_sb", 32'(sb_q.size()), 32'd0);

        // Stall for three cycles with pending entries and live requests
        load(2, 3, 1, 2);
        mask = 3'b101;
        push(2, 0, 0); push(2, 2, 0); push(2, 0, 1);
        push(2, 1, 0); push(2, 2, 1); push(2, 0, 2);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        mask = 3'b111;
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 1'b0);
            chk("stall_valid", 32'(bus.cdb_valid), 32'd1);
            chk("stall_src", 32'(bus.cdb_src), 32'd0);
            chk("stall_rob", 32'(bus.cdb_rob_id), 32'd24);
            chk("stall_ready", 32'(bus.req_ready), 32'h3);
            chk("stall_conf", 32'(bus.conflict_count), 32'd12);
        end
        drain("stall_drain");
        chk("stall_end_conf", 32'(bus.conflict_count), 32'd16);

        // Asynchronous reset between edges with entries pending
        load(3, 2, 2, 2);
        mask = 3'b111;
        push(3, 1, 0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        mask = '0;
        bus.req_valid = '0;
        chk("pre_rst_conf", 32'(bus.conflict_count), 32'd17);
        chk("pre_rst_valid", 32'(bus.cdb_valid), 32'd1);
        #3;
        rst_in = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.cdb_valid), 32'd0);
        chk("arst_ready", 32'(bus.req_ready), 32'h7);
        chk("arst_conf", 32'(bus.conflict_count), 32'd0);
        #1;
        rst_in = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cycle(1'b1, 1'b0);
            chk("post_rst_valid", 32'(bus.cdb_valid), 32'd0);
        end
        chk("final_sb", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
